// File: rtl/synth_pkg.sv
// Synth-wide constants shared by the oscillator bank and its controllers.
package synth_pkg;
   localparam int unsigned SYNTH_PHASE_ACC_BITS = 24;
endpackage

// File: rtl/voice_allocator.sv
// voice_allocator: polyphony controller for the oscillator bank.
// Accepts note-on/note-off events over a valid/ready handshake. Each note is
// mapped onto one of NUM_VOICES voices, and the allocator drives that voice's
// phase increment and a phase-reset pulse.
// Optional feature macro: VOICE_STEAL_EN. When it is defined, a note-on that
// finds no free voice steals the oldest voice. When it is undefined, such a
// note-on is dropped and drop_out pulses.
// Ports:
//   clk_in, rst_in    clock, synchronous active-high reset
//   evt_valid_in      event valid; evt_ready_out is the event ready
//   evt_on_in         1 = note-on, 0 = note-off
//   evt_key_in        note key
//   evt_incr_in       phase increment for a note-on
//   phase_incr_out    per-voice phase increment, voice i at [i*W +: W]
//   voice_active_out  per-voice sounding flag
//   voice_rst_out     per-voice 1-cycle phase-accumulator reset pulse
//   drop_out          1-cycle pulse when a note-on is discarded
module voice_allocator
   import synth_pkg::*;
#(
   parameter int unsigned NUM_VOICES = 8,
   parameter int unsigned KEY_BITS   = 7,
   parameter int unsigned AGE_BITS   = 8
) (
   input  logic                                       clk_in,
   input  logic                                       rst_in,
   input  logic                                       evt_valid_in,
   output logic                                       evt_ready_out,
   input  logic                                       evt_on_in,
   input  logic [KEY_BITS-1:0]                        evt_key_in,
   input  logic [SYNTH_PHASE_ACC_BITS-1:0]            evt_incr_in,
   output logic [NUM_VOICES*SYNTH_PHASE_ACC_BITS-1:0] phase_incr_out,
   output logic [NUM_VOICES-1:0]                      voice_active_out,
   output logic [NUM_VOICES-1:0]                      voice_rst_out,
   output logic                                       drop_out
);

   localparam int unsigned PW    = SYNTH_PHASE_ACC_BITS;
   localparam int unsigned IDX_W = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;
   localparam logic [IDX_W-1:0]    LAST_IDX = IDX_W'(NUM_VOICES - 1);
   localparam logic [AGE_BITS-1:0] AGE_MAX  = '1;
`ifdef VOICE_STEAL_EN
   localparam bit STEAL_EN = 1'b1;
`else
   localparam bit STEAL_EN = 1'b0;
`endif

   typedef enum logic [1:0] {ST_IDLE, ST_SCAN, ST_COMMIT} state_e;

   state_e                         state_q, state_d;
   logic                           ready_q, ready_d;
   logic [IDX_W-1:0]               scan_idx_q, scan_idx_d;

   // latched event
   logic                           ev_on_q, ev_on_d;
   logic [KEY_BITS-1:0]            ev_key_q, ev_key_d;
   logic [PW-1:0]                  ev_incr_q, ev_incr_d;

   // scan results
   logic                           match_found_q, match_found_d;
   logic [IDX_W-1:0]               match_idx_q, match_idx_d;
   logic                           free_found_q, free_found_d;
   logic [IDX_W-1:0]               free_idx_q, free_idx_d;
   logic                           old_found_q, old_found_d;
   logic [IDX_W-1:0]               old_idx_q, old_idx_d;
   logic [AGE_BITS-1:0]            old_age_q, old_age_d;

   // voice state
   logic [NUM_VOICES-1:0]          active_q, active_d;
   logic [KEY_BITS-1:0]            key_q [NUM_VOICES];
   logic [KEY_BITS-1:0]            key_d [NUM_VOICES];
   logic [AGE_BITS-1:0]            age_q [NUM_VOICES];
   logic [AGE_BITS-1:0]            age_d [NUM_VOICES];
   logic [NUM_VOICES*PW-1:0]       incr_q, incr_d;
   logic [NUM_VOICES-1:0]          voice_rst_q, voice_rst_d;
   logic                           drop_q, drop_d;

   logic                           tgt_ok;
   logic [IDX_W-1:0]               tgt_idx;

   // State and voice registers
   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         state_q       <= ST_IDLE;
         ready_q       <= 1'b0;
         scan_idx_q    <= '0;
         ev_on_q       <= 1'b0;
         ev_key_q      <= '0;
         ev_incr_q     <= '0;
         match_found_q <= 1'b0;
         match_idx_q   <= '0;
         free_found_q  <= 1'b0;
         free_idx_q    <= '0;
         old_found_q   <= 1'b0;
         old_idx_q     <= '0;
         old_age_q     <= '0;
         active_q      <= '0;
         key_q         <= '{default: '0};
         age_q         <= '{default: '0};
         incr_q        <= '0;
         voice_rst_q   <= '0;
         drop_q        <= 1'b0;
      end else begin
         state_q       <= state_d;
         ready_q       <= ready_d;
         scan_idx_q    <= scan_idx_d;
         ev_on_q       <= ev_on_d;
         ev_key_q      <= ev_key_d;
         ev_incr_q     <= ev_incr_d;
         match_found_q <= match_found_d;
         match_idx_q   <= match_idx_d;
         free_found_q  <= free_found_d;
         free_idx_q    <= free_idx_d;
         old_found_q   <= old_found_d;
         old_idx_q     <= old_idx_d;
         old_age_q     <= old_age_d;
         active_q      <= active_d;
         key_q         <= key_d;
         age_q         <= age_d;
         incr_q        <= incr_d;
         voice_rst_q   <= voice_rst_d;
         drop_q        <= drop_d;
      end
   end

   // Next-state: accept, serial scan, single-cycle commit
   always_comb begin
      state_d       = state_q;
      scan_idx_d    = scan_idx_q;
      ev_on_d       = ev_on_q;
      ev_key_d      = ev_key_q;
      ev_incr_d     = ev_incr_q;
      match_found_d = match_found_q;
      match_idx_d   = match_idx_q;
      free_found_d  = free_found_q;
      free_idx_d    = free_idx_q;
      old_found_d   = old_found_q;
      old_idx_d     = old_idx_q;
      old_age_d     = old_age_q;
      active_d      = active_q;
      key_d         = key_q;
      age_d         = age_q;
      incr_d        = incr_q;
      voice_rst_d   = '0;
      drop_d        = 1'b0;
      tgt_ok        = 1'b0;
      tgt_idx       = '0;

      case (state_q)
         ST_IDLE: begin
            // ready_q is only ever high while idle
            if (evt_valid_in && ready_q) begin
               ev_on_d       = evt_on_in;
               ev_key_d      = evt_key_in;
               ev_incr_d     = evt_incr_in;
               scan_idx_d    = '0;
               match_found_d = 1'b0;
               free_found_d  = 1'b0;
               old_found_d   = 1'b0;
               old_age_d     = '0;
               state_d       = ST_SCAN;
            end
         end
         ST_SCAN: begin
            if (active_q[scan_idx_q]) begin
               if (!match_found_q && (key_q[scan_idx_q] == ev_key_q)) begin
                  match_found_d = 1'b1;
                  match_idx_d   = scan_idx_q;
               end
               // strict '>' keeps the lowest index on an age tie
               if (!old_found_q || (age_q[scan_idx_q] > old_age_q)) begin
                  old_found_d = 1'b1;
                  old_idx_d   = scan_idx_q;
                  old_age_d   = age_q[scan_idx_q];
               end
            end else if (!free_found_q) begin
               free_found_d = 1'b1;
               free_idx_d   = scan_idx_q;
            end
            if (scan_idx_q == LAST_IDX) begin
               state_d = ST_COMMIT;
            end else begin
               scan_idx_d = scan_idx_q + IDX_W'(1);
            end
         end
         ST_COMMIT: begin
            state_d = ST_IDLE;
            if (ev_on_q) begin
               if (match_found_q) begin
                  tgt_ok  = 1'b1;
                  tgt_idx = match_idx_q;
               end else if (free_found_q) begin
                  tgt_ok  = 1'b1;
                  tgt_idx = free_idx_q;
               end else if (STEAL_EN) begin
                  tgt_ok  = 1'b1;
                  tgt_idx = old_idx_q;
               end else begin
                  drop_d = 1'b1;
               end
               if (tgt_ok) begin
                  for (int unsigned i = 0; i < NUM_VOICES; i++) begin
                     if (IDX_W'(i) == tgt_idx) begin
                        active_d[i]          = 1'b1;
                        key_d[i]             = ev_key_q;
                        age_d[i]             = '0;
                        incr_d[i*PW +: PW]   = ev_incr_q;
                        voice_rst_d[i]       = 1'b1;
                     end else if (active_q[i] && (age_q[i] != AGE_MAX)) begin
                        age_d[i] = age_q[i] + AGE_BITS'(1);
                     end
                  end
               end
            end else if (match_found_q) begin
               for (int unsigned i = 0; i < NUM_VOICES; i++) begin
                  if (IDX_W'(i) == match_idx_q) begin
                     active_d[i]        = 1'b0;
                     incr_d[i*PW +: PW] = '0;
                  end
               end
            end
         end
         default: state_d = ST_IDLE;
      endcase

      // one idle cycle with ready low after commit gives N+2 accept spacing
      ready_d = (state_q == ST_IDLE) && (state_d == ST_IDLE);
   end

   assign evt_ready_out    = ready_q;
   assign phase_incr_out   = incr_q;
   assign voice_active_out = active_q;
   assign voice_rst_out    = voice_rst_q;
   assign drop_out         = drop_q;

endmodule

// File: tb/tb_voice_allocator.sv
// Directed, table-driven bench for voice_allocator.
module tb_voice_allocator;
   import synth_pkg::*;

   localparam int unsigned N  = 8;
   localparam int unsigned KB = 7;
   localparam int unsigned W  = SYNTH_PHASE_ACC_BITS;

   logic              clk_in;
   logic              rst_in;
   logic              evt_valid_in;
   logic              evt_ready_out;
   logic              evt_on_in;
   logic [KB-1:0]     evt_key_in;
   logic [W-1:0]      evt_incr_in;
   logic [N*W-1:0]    phase_incr_out;
   logic [N-1:0]      voice_active_out;
   logic [N-1:0]      voice_rst_out;
   logic              drop_out;

   int checks = 0;
   int errors = 0;

   voice_allocator #(.NUM_VOICES(N), .KEY_BITS(KB), .AGE_BITS(8)) dut (
      .clk_in           (clk_in),
      .rst_in           (rst_in),
      .evt_valid_in     (evt_valid_in),
      .evt_ready_out    (evt_ready_out),
      .evt_on_in        (evt_on_in),
      .evt_key_in       (evt_key_in),
      .evt_incr_in      (evt_incr_in),
      .phase_incr_out   (phase_incr_out),
      .voice_active_out (voice_active_out),
      .voice_rst_out    (voice_rst_out),
      .drop_out         (drop_out)
   );

   initial clk_in = 1'b0;
   always #5 clk_in = ~clk_in;

   typedef struct {
      bit          on;
      int          key;
      int          incr;
      logic [7:0]  exp_active;
      logic [7:0]  exp_rst;
      bit          exp_drop;
      int          chk_v;
      int          chk_incr;
   } vec_t;

   vec_t tbl[$];

   function automatic vec_t mk(bit on, int key, int incr, int act, int rs,
                               bit drp, int cv, int ci);
      vec_t v;
      v.on = on; v.key = key; v.incr = incr;
      v.exp_active = 8'(act); v.exp_rst = 8'(rs); v.exp_drop = drp;
      v.chk_v = cv; v.chk_incr = ci;
      return v;
   endfunction

   task automatic check(input string nm, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h", nm, got, exp);
      end
   endtask

   task automatic check_all_zero(input string nm);
      check({nm, " active"}, 64'(voice_active_out), 64'd0);
      check({nm, " incr"},   64'(phase_incr_out != '0), 64'd0);
      check({nm, " vrst"},   64'(voice_rst_out), 64'd0);
      check({nm, " drop"},   64'(drop_out), 64'd0);
      check({nm, " ready"},  64'(evt_ready_out), 64'd0);
   endtask

   // Drive one event, wait for ready to return, and check the result
   task automatic apply(input vec_t v, input int idx);
      int          n;
      int          low;
      int          pulse_cyc;
      logic [N-1:0] rst_seen;
      logic        drop_seen;
      string       nm;
      nm = $sformatf("ev%0d", idx);
      @(negedge clk_in);
      evt_valid_in = 1'b1;
      evt_on_in    = v.on;
      evt_key_in   = KB'(v.key);
      evt_incr_in  = W'(v.incr);
      n = 0;
      while (!evt_ready_out && n < 40) begin
         @(negedge clk_in);
         n++;
      end
      if (!evt_ready_out) begin
         checks++; errors++;
         $display("FAIL %s accept timeout got=ready0 exp=ready1", nm);
         evt_valid_in = 1'b0;
         return;
      end
      @(posedge clk_in);
      #1 evt_valid_in = 1'b0;
      rst_seen = '0; drop_seen = 1'b0; pulse_cyc = 0; low = 0;
      @(negedge clk_in);
      while (!evt_ready_out && low < 40) begin
         low++;
         rst_seen  |= voice_rst_out;
         drop_seen |= drop_out;
         if (voice_rst_out != '0 || drop_out) pulse_cyc++;
         @(negedge clk_in);
      end
      check({nm, " ready_low_cycles"}, 64'(low), 64'(N + 2));
      check({nm, " active"}, 64'(voice_active_out), 64'(v.exp_active));
      check({nm, " vrst"}, 64'(rst_seen), 64'(v.exp_rst));
      check({nm, " drop"}, 64'(drop_seen), 64'(v.exp_drop));
      check({nm, " pulse_cycles"}, 64'(pulse_cyc),
            64'((v.exp_rst != 0 || v.exp_drop) ? 1 : 0));
      check($sformatf("%s incr_v%0d", nm, v.chk_v),
            64'(phase_incr_out[v.chk_v*W +: W]), 64'(v.chk_incr));
      for (int i = 0; i < int'(N); i++) begin
         if (!v.exp_active[i])
            check($sformatf("%s idle_incr_v%0d", nm, i),
                  64'(phase_incr_out[i*W +: W]), 64'd0);
      end
   endtask

   initial begin
      logic [N-1:0] act_seen;
      logic [N-1:0] rst_seen;
      logic         drop_seen;

      // 0..6: basic allocation, note-off, reuse, retrigger, unknown note-off
      tbl.push_back(mk(1, 60, 'h1000, 'h01, 'h01, 0, 0, 'h1000));
      tbl.push_back(mk(1, 62, 'h1100, 'h03, 'h02, 0, 1, 'h1100));
      tbl.push_back(mk(1, 64, 'h1200, 'h07, 'h04, 0, 2, 'h1200));
      tbl.push_back(mk(0, 62, 0,      'h05, 'h00, 0, 1, 0));
      tbl.push_back(mk(1, 67, 'h1300, 'h07, 'h02, 0, 1, 'h1300));
      tbl.push_back(mk(1, 60, 'h2000, 'h07, 'h01, 0, 0, 'h2000));
      tbl.push_back(mk(0, 99, 0,      'h07, 'h00, 0, 0, 'h2000));
      // 7..14: fill all voices with keys 0..7 after a reset
      for (int k = 0; k < 8; k++)
         tbl.push_back(mk(1, k, (k + 1) * 'h100, (1 << (k + 1)) - 1, 1 << k, 0, k, (k + 1) * 'h100));
      // full bank: voice0 is oldest (age 7), then voice1
`ifdef VOICE_STEAL_EN
      tbl.push_back(mk(1, 9,  'h900, 'hFF, 'h01, 0, 0, 'h900));
      tbl.push_back(mk(1, 10, 'hA00, 'hFF, 'h02, 0, 1, 'hA00));
`else
      tbl.push_back(mk(1, 9,  'h900, 'hFF, 'h00, 1, 0, 'h100));
      tbl.push_back(mk(1, 10, 'hA00, 'hFF, 'h00, 1, 1, 'h200));
`endif
      tbl.push_back(mk(0, 3,  0,     'hF7, 'h00, 0, 3, 0));
      tbl.push_back(mk(1, 11, 'hB00, 'hFF, 'h08, 0, 3, 'hB00));

      rst_in = 1'b1; evt_valid_in = 1'b0; evt_on_in = 1'b0;
      evt_key_in = '0; evt_incr_in = '0;

      // reset state
      repeat (3) @(posedge clk_in);
      #1 check_all_zero("reset");
      @(negedge clk_in);
      rst_in = 1'b0;
      check("reset_release ready", 64'(evt_ready_out), 64'd0);
      @(posedge clk_in);
      #1 check("post_reset ready", 64'(evt_ready_out), 64'd1);

      for (int i = 0; i < 7; i++) apply(tbl[i], i);

      // reset in the middle of a note-on scan aborts it
      @(negedge clk_in);
      evt_valid_in = 1'b1; evt_on_in = 1'b1; evt_key_in = KB'(5); evt_incr_in = W'('h500);
      @(posedge clk_in);
      #1 evt_valid_in = 1'b0;
      repeat (3) @(posedge clk_in);
      @(negedge clk_in);
      rst_in = 1'b1;
      @(posedge clk_in);
      #1 check_all_zero("midscan_reset");
      @(negedge clk_in);
      rst_in = 1'b0;
      check("midscan_release ready", 64'(evt_ready_out), 64'd0);
      @(posedge clk_in);
      #1 check("midscan_post ready", 64'(evt_ready_out), 64'd1);
      act_seen = '0; rst_seen = '0; drop_seen = 1'b0;
      repeat (N + 4) begin
         @(negedge clk_in);
         act_seen  |= voice_active_out;
         rst_seen  |= voice_rst_out;
         drop_seen |= drop_out;
      end
      check("midscan_aborted active", 64'(act_seen), 64'd0);
      check("midscan_aborted vrst", 64'(rst_seen), 64'd0);
      check("midscan_aborted drop", 64'(drop_seen), 64'd0);

      for (int i = 7; i < tbl.size(); i++) apply(tbl[i], i);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
